// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Conditions a raw asynchronous level input (button, switch, external strobe)
// before it reaches the edge detector. The input first passes through an
// N-flop synchroniser. A counter-based FSM then qualifies every level change.
// in_clean only changes after the synchronised level has held its new value
// for DEBOUNCE_CYCLES+1 consecutive clock edges. Any revert during that
// window discards the qualification and restarts it from zero.
//
// Parameters
//   SYNC_STAGES      synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES  stability window in clk cycles (>= 1)
//   RESET_LEVEL      value loaded into sync flops and in_clean during reset
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_raw      in   raw asynchronous level input
//   in_clean    out  debounced, synchronised level (registered)
//   settling    out  high while a level change is being qualified (registered)
//   rise_pulse  out  one-cycle pulse on in_clean 0->1 (DEBOUNCER_EDGE_OUT_EN only)
//   fall_pulse  out  one-cycle pulse on in_clean 1->0 (DEBOUNCER_EDGE_OUT_EN only)
//
// Optional feature
//   Define DEBOUNCER_EDGE_OUT_EN to add the rise_pulse/fall_pulse outputs.
//   When the macro is undefined those ports and their logic are absent.
//
// Handshake: none. The block is a free-running level filter. in_clean is
// valid on every cycle, and there is no backpressure.
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_raw,
    output logic in_clean,
    output logic settling
`ifdef DEBOUNCER_EDGE_OUT_EN
    ,
    output logic rise_pulse,
    output logic fall_pulse
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    // Synchroniser: a plain shift chain with no logic between the flops.
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in_raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Debounce FSM
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             clean_next;
    logic             settling_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_STATE;
            cnt      <= '0;
            in_clean <= RESET_LEVEL;
            settling <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            in_clean <= clean_next;
            settling <= settling_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clean_next = in_clean;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    state_next = CHECK_HI;
                    cnt_next   = '0;
                end
            end
            CHECK_HI: begin
                if (!s) begin
                    // A glitch is rejected here, and in_clean keeps its level.
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_HI;
                    clean_next = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_next = CHECK_LO;
                    cnt_next   = '0;
                end
            end
            CHECK_LO: begin
                if (s) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_LO;
                    clean_next = 1'b0;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = RESET_STATE;
                cnt_next   = '0;
            end
        endcase
        // settling is registered from the next state. It rises on the edge
        // that enters CHECK_* and falls on the edge that leaves it.
        settling_next = (state_next == CHECK_HI) || (state_next == CHECK_LO);
    end

`ifdef DEBOUNCER_EDGE_OUT_EN
    // The pulses are registered from the same next-level compare. Each pulse
    // therefore coincides with the in_clean transition. Both pulses cannot be
    // high together, because in_clean moves in only one direction per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= clean_next & ~in_clean;
            fall_pulse <= ~clean_next & in_clean;
        end
    end
`endif

endmodule
